// File: rtl/synchronous_fifo_controller_pkg.sv
// Shared helpers for the synchronous FIFO controller: pointer wrap and fill-level arithmetic.
package synchronous_fifo_controller_pkg;

    // Next index of a pointer that counts 0..depth-1 and then wraps.
    function automatic int unsigned wrap_increment(input int unsigned index,
                                                   input int unsigned depth);
        return (index == depth - 1) ? 0 : index + 1;
    endfunction

    // Laps differing means the writer is one lap ahead, so the span crosses the wrap point.
    function automatic int unsigned fifo_level(input int unsigned write_index,
                                               input int unsigned read_index,
                                               input logic        laps_differ,
                                               input int unsigned depth);
        return laps_differ ? depth + write_index - read_index : write_index - read_index;
    endfunction

endpackage

// File: rtl/synchronous_fifo_controller_pointer.sv
// FIFO pointer: index counting modulo DEPTH plus a lap bit that toggles on every wrap.
module fifo_pointer_counter
    import synchronous_fifo_controller_pkg::*;
#(
    parameter  int unsigned DEPTH      = 4,
    localparam int unsigned DEPTH_LOG2 = $clog2(DEPTH)
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  enable,
    output logic [DEPTH_LOG2-1:0] index,
    output logic                  lap
);

    logic [DEPTH_LOG2-1:0] index_q, index_d;
    logic                  lap_q, lap_d;

    always_comb begin
        index_d = index_q;
        lap_d   = lap_q;
        if (enable) begin
            index_d = DEPTH_LOG2'(wrap_increment(32'(index_q), DEPTH));
            if (index_q == DEPTH_LOG2'(DEPTH - 1)) begin
                lap_d = ~lap_q;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            index_q <= '0;
            lap_q   <= 1'b0;
        end else begin
            index_q <= index_d;
            lap_q   <= lap_d;
        end
    end

    assign index = index_q;
    assign lap   = lap_q;

endmodule

// File: rtl/synchronous_fifo_controller.sv
// Single-clock FIFO controller driving an external simple dual-port RAM with combinational read.
module synchronous_fifo_controller
    import synchronous_fifo_controller_pkg::*;
#(
    parameter  int unsigned WIDTH       = 8,
    parameter  int unsigned DEPTH       = 4,
    localparam int unsigned DEPTH_LOG2  = $clog2(DEPTH),
    localparam int unsigned LEVEL_WIDTH = $clog2(DEPTH + 1)
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   write_enable,
    input  logic [WIDTH-1:0]       write_data,
    output logic                   write_full,
    output logic                   write_miss,
    input  logic                   read_enable,
    output logic [WIDTH-1:0]       read_data,
    output logic                   read_empty,
    output logic                   read_error,
    output logic [LEVEL_WIDTH-1:0] level,
    output logic                   memory_clock,
    output logic                   memory_write_enable,
    output logic [DEPTH_LOG2-1:0]  memory_write_address,
    output logic [WIDTH-1:0]       memory_write_data,
    output logic                   memory_read_enable,
    output logic [DEPTH_LOG2-1:0]  memory_read_address,
    input  logic [WIDTH-1:0]       memory_read_data
);

    logic [DEPTH_LOG2-1:0] write_index, read_index;
    logic                  write_lap, read_lap;
    logic                  push_accept, pop_accept;
    logic                  write_miss_q, write_miss_d;
    logic                  read_error_q, read_error_d;

    // Gating with resetn keeps the RAM untouched while reset is asserted.
    assign push_accept = resetn && write_enable && !write_full;
    assign pop_accept  = resetn && read_enable && !read_empty;

    fifo_pointer_counter #(
        .DEPTH (DEPTH)
    ) u_write_pointer (
        .clock  (clock),
        .resetn (resetn),
        .enable (push_accept),
        .index  (write_index),
        .lap    (write_lap)
    );

    fifo_pointer_counter #(
        .DEPTH (DEPTH)
    ) u_read_pointer (
        .clock  (clock),
        .resetn (resetn),
        .enable (pop_accept),
        .index  (read_index),
        .lap    (read_lap)
    );

    assign read_empty = (write_index == read_index) && (write_lap == read_lap);
    assign write_full = (write_index == read_index) && (write_lap != read_lap);
    assign level      = LEVEL_WIDTH'(fifo_level(32'(write_index), 32'(read_index),
                                                write_lap != read_lap, DEPTH));

    always_comb begin
        write_miss_d = write_enable && write_full;
        read_error_d = read_enable && read_empty;
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            write_miss_q <= 1'b0;
            read_error_q <= 1'b0;
        end else begin
            write_miss_q <= write_miss_d;
            read_error_q <= read_error_d;
        end
    end

    assign write_miss = write_miss_q;
    assign read_error = read_error_q;

    assign memory_clock         = clock;
    assign memory_write_enable  = push_accept;
    assign memory_write_address = write_index;
    assign memory_write_data    = write_data;
    assign memory_read_enable   = !read_empty;
    assign memory_read_address  = read_index;
    assign read_data            = memory_read_data;

endmodule

// File: tb/tb_synchronous_fifo_controller.sv
// Drives a DEPTH=4 and a DEPTH=3 controller with the same stimulus against a queue model.
module tb_synchronous_fifo_controller;

    typedef logic [7:0] byte_q_t[$];

    logic       clock = 1'b0;
    logic       resetn;
    logic       we, re;
    logic [7:0] wd;

    logic [1:0] full_s, miss_s, err_s, empty_s, mwe_s, mre_s, mclk_s;
    logic [1:0] mwa_s [2];
    logic [1:0] mra_s [2];
    logic [7:0] mwd_s [2];
    logic [7:0] rdat_s[2];
    logic [7:0] mrd_s [2];
    logic [2:0] lvl_s [2];
    logic [1:0] lvl3;
    logic [7:0] mem   [2][4];

    int          checks = 0;
    int          errors = 0;
    bit          checking = 1'b0;
    int unsigned mdepth[2] = '{4, 3};
    byte_q_t     mq[2];
    int unsigned wcnt[2], rcnt[2];
    logic        xmiss[2], xerr[2];
    int unsigned sz_m;

    always #5 clock = ~clock;

    synchronous_fifo_controller #(.WIDTH(8), .DEPTH(4)) dut4 (
        .clock(clock), .resetn(resetn),
        .write_enable(we), .write_data(wd), .write_full(full_s[0]), .write_miss(miss_s[0]),
        .read_enable(re), .read_data(rdat_s[0]), .read_empty(empty_s[0]),
        .read_error(err_s[0]), .level(lvl_s[0]), .memory_clock(mclk_s[0]),
        .memory_write_enable(mwe_s[0]), .memory_write_address(mwa_s[0]),
        .memory_write_data(mwd_s[0]), .memory_read_enable(mre_s[0]),
        .memory_read_address(mra_s[0]), .memory_read_data(mrd_s[0])
    );

    synchronous_fifo_controller #(.WIDTH(8), .DEPTH(3)) dut3 (
        .clock(clock), .resetn(resetn),
        .write_enable(we), .write_data(wd), .write_full(full_s[1]), .write_miss(miss_s[1]),
        .read_enable(re), .read_data(rdat_s[1]), .read_empty(empty_s[1]),
        .read_error(err_s[1]), .level(lvl3), .memory_clock(mclk_s[1]),
        .memory_write_enable(mwe_s[1]), .memory_write_address(mwa_s[1]),
        .memory_write_data(mwd_s[1]), .memory_read_enable(mre_s[1]),
        .memory_read_address(mra_s[1]), .memory_read_data(mrd_s[1])
    );

    assign lvl_s[1] = {1'b0, lvl3};

    // Behavioural simple dual-port RAMs, combinational read.
    always @(posedge clock) begin
        for (int i = 0; i < 2; i++) begin
            if (mwe_s[i]) mem[i][mwa_s[i]] <= mwd_s[i];
        end
    end
    assign mrd_s[0] = mem[0][mra_s[0]];
    assign mrd_s[1] = mem[1][mra_s[1]];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Queue model: accept decisions use the occupancy before the edge.
    always @(posedge clock) begin
        for (int i = 0; i < 2; i++) begin
            if (!resetn) begin
                mq[i].delete();
                wcnt[i]  = 0;
                rcnt[i]  = 0;
                xmiss[i] = 1'b0;
                xerr[i]  = 1'b0;
            end else begin
                sz_m     = mq[i].size();
                xmiss[i] = we && (sz_m == mdepth[i]);
                xerr[i]  = re && (sz_m == 0);
                if (re && sz_m > 0) begin
                    void'(mq[i].pop_front());
                    rcnt[i]++;
                end
                if (we && sz_m < mdepth[i]) begin
                    mq[i].push_back(wd);
                    wcnt[i]++;
                end
            end
        end
    end

    always @(negedge clock) begin
        if (checking) begin
            for (int i = 0; i < 2; i++) begin
                automatic int unsigned sz  = mq[i].size();
                automatic logic        xwe = resetn && we && (sz < mdepth[i]);
                automatic string       p   = $sformatf("d%0d_", mdepth[i]);
                chk({p, "empty"}, 32'(empty_s[i]), 32'(sz == 0));
                chk({p, "full"}, 32'(full_s[i]), 32'(sz == mdepth[i]));
                chk({p, "level"}, 32'(lvl_s[i]), sz);
                chk({p, "miss"}, 32'(miss_s[i]), 32'(xmiss[i]));
                chk({p, "error"}, 32'(err_s[i]), 32'(xerr[i]));
                chk({p, "mem_re"}, 32'(mre_s[i]), 32'(sz != 0));
                chk({p, "mem_we"}, 32'(mwe_s[i]), 32'(xwe));
                chk({p, "mem_clk"}, 32'(mclk_s[i]), 32'(clock));
                if (sz != 0) begin
                    chk({p, "rdata"}, 32'(rdat_s[i]), 32'(mq[i][0]));
                    chk({p, "raddr"}, 32'(mra_s[i]), rcnt[i] % mdepth[i]);
                end
                if (xwe) begin
                    chk({p, "waddr"}, 32'(mwa_s[i]), wcnt[i] % mdepth[i]);
                    chk({p, "wdata"}, 32'(mwd_s[i]), 32'(wd));
                end
            end
        end
    end

    task automatic drive(input logic w, input logic [7:0] d, input logic r, input logic n);
        we     = w;
        wd     = d;
        re     = r;
        resetn = n;
        #2;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        tick();
        checking = 1'b1;
        tick();
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        chk("reset_empty", 32'(empty_s[0]), 32'd1);
        chk("reset_full", 32'(full_s[0]), 32'd0);
        chk("reset_level", 32'(lvl_s[0]), 32'd0);
        chk("reset_mem_we", 32'(mwe_s[0]), 32'd0);
        chk("reset_mem_re", 32'(mre_s[0]), 32'd0);

        // Fill: DEPTH=4 fills exactly, DEPTH=3 misses the fourth push.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'(8'h11 * (i + 1)), 1'b0, 1'b1);
            tick();
        end
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        chk("fill_full4", 32'(full_s[0]), 32'd1);
        chk("fill_level4", 32'(lvl_s[0]), 32'd4);
        chk("fill_full3", 32'(full_s[1]), 32'd1);
        chk("fill_level3", 32'(lvl_s[1]), 32'd3);
        chk("fill_miss3", 32'(miss_s[1]), 32'd1);

        drive(1'b1, 8'h55, 1'b0, 1'b1);
        chk("ovf_no_write", 32'(mwe_s[0]), 32'd0);
        tick();
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        chk("ovf_miss", 32'(miss_s[0]), 32'd1);
        chk("ovf_level", 32'(lvl_s[0]), 32'd4);
        tick();
        chk("ovf_miss_clear", 32'(miss_s[0]), 32'd0);

        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 8'h00, 1'b1, 1'b1);
            chk("drain_data", 32'(rdat_s[0]), 32'(8'h11 * (i + 1)));
            tick();
        end
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        chk("drain_empty", 32'(empty_s[0]), 32'd1);
        chk("drain_err3", 32'(err_s[1]), 32'd1);

        drive(1'b0, 8'h00, 1'b1, 1'b1);
        tick();
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        chk("udf_error", 32'(err_s[0]), 32'd1);
        chk("udf_level", 32'(lvl_s[0]), 32'd0);

        // Alternating push/pop: DEPTH=3 addresses must cycle 0,1,2,0,...
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 8'(i), 1'b0, 1'b1);
            chk("pair_waddr3", 32'(mwa_s[1]), 32'(i % 3));
            tick();
            drive(1'b0, 8'h00, 1'b1, 1'b1);
            chk("pair_rdata3", 32'(rdat_s[1]), 32'(i));
            chk("pair_raddr3", 32'(mra_s[1]), 32'(i % 3));
            tick();
        end

        drive(1'b1, 8'hA0, 1'b0, 1'b1);
        tick();
        drive(1'b1, 8'hA1, 1'b0, 1'b1);
        tick();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 8'(8'hB0 + i), 1'b1, 1'b1);
            tick();
        end
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        chk("sim_level4", 32'(lvl_s[0]), 32'd2);
        chk("sim_level3", 32'(lvl_s[1]), 32'd2);
        chk("sim_head4", 32'(rdat_s[0]), 32'hB6);

        drive(1'b1, 8'hC0, 1'b0, 1'b1);
        tick();
        drive(1'b1, 8'hC1, 1'b0, 1'b1);
        tick();
        drive(1'b1, 8'hD0, 1'b1, 1'b1);
        chk("full_pp_no_write", 32'(mwe_s[0]), 32'd0);
        tick();
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        chk("full_pp_miss", 32'(miss_s[0]), 32'd1);
        chk("full_pp_level", 32'(lvl_s[0]), 32'd3);
        chk("full_pp_head", 32'(rdat_s[0]), 32'hB7);

        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 8'h00, 1'b1, 1'b1);
            tick();
        end
        drive(1'b1, 8'hE0, 1'b1, 1'b1);
        tick();
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        chk("empty_pp_error", 32'(err_s[0]), 32'd1);
        chk("empty_pp_level", 32'(lvl_s[0]), 32'd1);
        chk("empty_pp_head", 32'(rdat_s[0]), 32'hE0);

        drive(1'b1, 8'hE1, 1'b0, 1'b1);
        tick();
        drive(1'b1, 8'hE2, 1'b0, 1'b1);
        tick();
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        chk("pre_rst_level", 32'(lvl_s[0]), 32'd3);
        drive(1'b1, 8'hF0, 1'b0, 1'b0);
        chk("rst_no_write", 32'(mwe_s[0]), 32'd0);
        tick();
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        chk("rst_empty", 32'(empty_s[0]), 32'd1);
        chk("rst_level", 32'(lvl_s[0]), 32'd0);
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
